// File: rtl/player_controller.sv
// rtl/player_controller.sv - tile-grid player movement with ROM wall check
// Optional feature macro: PLAYER_WRAP_EN (off-grid moves wrap around instead of being rejected).
module player_controller #(
    parameter int MAP_COLS = 21,
    parameter int MAP_ROWS = 30,
    parameter int START_X  = 1,
    parameter int START_Y  = 1,
    parameter int MOVE_DIV = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    output logic [$clog2(MAP_COLS)-1:0] map_addr,
    input  logic [MAP_ROWS-1:0]         map_data,
    output logic [7:0]                  player_x_pos,
    output logic [7:0]                  player_y_pos,
    output logic                        busy,
    output logic                        moved,
    output logic                        blocked
);

    localparam int AW    = $clog2(MAP_COLS);
    localparam int YW    = $clog2(MAP_ROWS);
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic signed [8:0] COLS_S = 9'(MAP_COLS);
    localparam logic signed [8:0] ROWS_S = 9'(MAP_ROWS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    // Button vectors are ordered {up, down, left, right}.
    logic [3:0]       btn_meta_q, btn_sync_q;
    logic [1:0]       state_q, state_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic [AW-1:0]    tgt_x_q, tgt_x_d;
    logic [YW-1:0]    tgt_y_q, tgt_y_d;
    logic [CNT_W-1:0] rate_cnt_q, rate_cnt_d;
    logic             moved_q, moved_d, blocked_q, blocked_d;

    logic              held, due, off_grid;
    logic signed [8:0] dx, dy, nx, ny;
    logic [AW-1:0]     cand_x;
    logic [YW-1:0]     cand_y;

    assign held = |btn_sync_q;
    assign due  = frame_tick && held && (rate_cnt_q == '0);

    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_sync_q[3])      dy = -9'sd1;
        else if (btn_sync_q[2]) dy = 9'sd1;
        else if (btn_sync_q[1]) dx = -9'sd1;
        else if (btn_sync_q[0]) dx = 9'sd1;
    end

    assign nx = $signed({1'b0, x_q}) + dx;
    assign ny = $signed({1'b0, y_q}) + dy;

`ifdef PLAYER_WRAP_EN
    assign off_grid = 1'b0;
    assign cand_x = (nx < 0) ? AW'(MAP_COLS - 1) : (nx >= COLS_S) ? '0 : nx[AW-1:0];
    assign cand_y = (ny < 0) ? YW'(MAP_ROWS - 1) : (ny >= ROWS_S) ? '0 : ny[YW-1:0];
`else
    assign off_grid = (nx < 0) || (nx >= COLS_S) || (ny < 0) || (ny >= ROWS_S);
    assign cand_x = nx[AW-1:0];
    assign cand_y = ny[YW-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        moved_d    = 1'b0;
        blocked_d  = 1'b0;
        rate_cnt_d = rate_cnt_q;

        // Counter keeps running on ticks even while a move is in flight.
        if (!held)
            rate_cnt_d = '0;
        else if (frame_tick)
            rate_cnt_d = (rate_cnt_q == CNT_W'(MOVE_DIV - 1)) ? '0 : rate_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (due) begin
                    if (off_grid) begin
                        blocked_d = 1'b1;
                    end else begin
                        tgt_x_d = cand_x;
                        tgt_y_d = cand_y;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_CHECK;
            S_CHECK: begin
                if (!map_data[tgt_y_q]) begin
                    x_d     = 8'(tgt_x_q);
                    y_d     = 8'(tgt_y_q);
                    moved_d = 1'b1;
                end else begin
                    blocked_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            state_q    <= S_IDLE;
            x_q        <= 8'(START_X);
            y_q        <= 8'(START_Y);
            tgt_x_q    <= AW'(START_X);
            tgt_y_q    <= YW'(START_Y);
            rate_cnt_q <= '0;
            moved_q    <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            btn_meta_q <= {btn_up, btn_down, btn_left, btn_right};
            btn_sync_q <= btn_meta_q;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            rate_cnt_q <= rate_cnt_d;
            moved_q    <= moved_d;
            blocked_q  <= blocked_d;
        end
    end

    assign map_addr     = tgt_x_q;
    assign player_x_pos = x_q;
    assign player_y_pos = y_q;
    assign busy         = (state_q != S_IDLE);
    assign moved        = moved_q;
    assign blocked      = blocked_q;

endmodule

// File: tb/tb_player_controller.sv
// tb/tb_player_controller.sv - directed self-checking bench for player_controller
module tb_player_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [4:0]  map_addr;
    logic [29:0] map_data = '0;
    logic [7:0]  player_x_pos, player_y_pos;
    logic        busy, moved, blocked;

    logic [29:0] rom [0:20];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Registered wall ROM, one cycle of latency.
    always @(posedge clk) map_data <= (map_addr < 5'd21) ? rom[map_addr] : '0;

    player_controller dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .map_addr(map_addr), .map_data(map_data),
        .player_x_pos(player_x_pos), .player_y_pos(player_y_pos),
        .busy(busy), .moved(moved), .blocked(blocked)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btns(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    endtask

    // Leaves the bench one cycle after the tick edge (T+1).
    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic do_move(input logic u, input logic d, input logic l, input logic r);
        set_btns(u, d, l, r);
        step(3);
        pulse_tick();
        step(2);
        set_btns(0, 0, 0, 0);
        step(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        checks++; if (player_x_pos !== 8'd1) begin errors++; $display("FAIL reset_x got %0d want 1", player_x_pos); end
        checks++; if (player_y_pos !== 8'd1) begin errors++; $display("FAIL reset_y got %0d want 1", player_y_pos); end
        checks++; if (map_addr !== 5'd1) begin errors++; $display("FAIL reset_addr got %0d want 1", map_addr); end
        checks++; if ({busy, moved, blocked} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, moved, blocked}); end
    endtask

    task automatic test_wall_block();
        rom[2] = 30'h2;
        set_btns(0, 0, 0, 1);
        step(3);
        pulse_tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wall_fetch_busy got %b want 1", busy); end
        checks++; if (map_addr !== 5'd2) begin errors++; $display("FAIL wall_fetch_addr got %0d want 2", map_addr); end
        step(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wall_check_busy got %b want 1", busy); end
        step(1);
        checks++; if ({blocked, moved, busy} !== 3'b100) begin errors++; $display("FAIL wall_pulse got %b want 100", {blocked, moved, busy}); end
        checks++; if (player_x_pos !== 8'd1) begin errors++; $display("FAIL wall_x got %0d want 1", player_x_pos); end
        step(1);
        checks++; if (blocked !== 1'b0) begin errors++; $display("FAIL wall_pulse_len got %b want 0", blocked); end
        set_btns(0, 0, 0, 0);
        step(4);
        rom[2] = '0;
    endtask

    task automatic test_repeat();
        int n_moves;
        int last_k;
        n_moves = 0;
        last_k  = -1;
        set_btns(0, 0, 0, 1);
        step(3);
        pulse_tick();
        step(2);
        checks++; if (moved !== 1'b1) begin errors++; $display("FAIL repeat_first_moved got %b want 1", moved); end
        checks++; if (player_x_pos !== 8'd2 || player_y_pos !== 8'd1) begin errors++; $display("FAIL repeat_first_pos got (%0d,%0d) want (2,1)", player_x_pos, player_y_pos); end
        for (int k = 1; k <= 8; k++) begin
            pulse_tick();
            for (int c = 0; c < 4; c++) begin
                if (moved) begin n_moves++; last_k = k; end
                step(1);
            end
        end
        checks++; if (n_moves !== 1) begin errors++; $display("FAIL repeat_count got %0d want 1", n_moves); end
        checks++; if (last_k !== 8) begin errors++; $display("FAIL repeat_tick got %0d want 8", last_k); end
        checks++; if (player_x_pos !== 8'd3) begin errors++; $display("FAIL repeat_x got %0d want 3", player_x_pos); end
        set_btns(0, 0, 0, 0);
        step(4);
    endtask

    task automatic test_priority_ignore();
        int n_moves;
        n_moves = 0;
        set_btns(1, 0, 0, 1);
        step(3);
        frame_tick = 1'b1;
        step(2);
        frame_tick = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (moved) n_moves++;
            step(1);
        end
        checks++; if (n_moves !== 1) begin errors++; $display("FAIL prio_count got %0d want 1", n_moves); end
        checks++; if (player_x_pos !== 8'd3 || player_y_pos !== 8'd0) begin errors++; $display("FAIL prio_pos got (%0d,%0d) want (3,0)", player_x_pos, player_y_pos); end
        set_btns(0, 0, 0, 0);
        step(4);
    endtask

    task automatic test_edge_left();
        for (int i = 0; i < 3; i++) do_move(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) do_move(0, 1, 0, 0);
        checks++; if (player_x_pos !== 8'd0 || player_y_pos !== 8'd5) begin errors++; $display("FAIL edge_setup got (%0d,%0d) want (0,5)", player_x_pos, player_y_pos); end
        set_btns(0, 0, 1, 0);
        step(3);
        pulse_tick();
`ifdef PLAYER_WRAP_EN
        checks++; if (busy !== 1'b1 || map_addr !== 5'd20) begin errors++; $display("FAIL wrap_fetch got busy=%b addr=%0d want busy=1 addr=20", busy, map_addr); end
        step(2);
        checks++; if (moved !== 1'b1 || player_x_pos !== 8'd20) begin errors++; $display("FAIL wrap_commit got moved=%b x=%0d want moved=1 x=20", moved, player_x_pos); end
`else
        checks++; if (blocked !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL edge_block got blocked=%b busy=%b want blocked=1 busy=0", blocked, busy); end
        step(1);
        checks++; if (blocked !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL edge_after got blocked=%b busy=%b want 0 0", blocked, busy); end
        step(1);
        checks++; if (player_x_pos !== 8'd0 || moved !== 1'b0) begin errors++; $display("FAIL edge_pos got x=%0d moved=%b want x=0 moved=0", player_x_pos, moved); end
`endif
        set_btns(0, 0, 0, 0);
        step(4);
    endtask

    task automatic test_reset_in_check();
        set_btns(0, 1, 0, 0);
        step(3);
        pulse_tick();
        step(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_check_busy got %b want 1", busy); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        set_btns(0, 0, 0, 0);
        checks++; if ({moved, blocked, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {moved, blocked, busy}); end
        checks++; if (player_x_pos !== 8'd1 || player_y_pos !== 8'd1) begin errors++; $display("FAIL rst_pos got (%0d,%0d) want (1,1)", player_x_pos, player_y_pos); end
        checks++; if (map_addr !== 5'd1) begin errors++; $display("FAIL rst_addr got %0d want 1", map_addr); end
        step(1);
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL rst_late_moved got %b want 0", moved); end
    endtask

    initial begin
        for (int i = 0; i < 21; i++) rom[i] = '0;
        test_reset();
        test_wall_block();
        test_repeat();
        test_priority_ignore();
        test_edge_left();
        test_reset_in_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
